conv_requant_out: RTL
=====================

Name: conv_requant_out

Overview:
Downstream stage of the 8x4 convolution engine. Consumes the signed 18-bit y result stream over a valid/ready handshake. Applies round-half-up arithmetic right shift and saturates each result to signed 8-bit. Buffers results in a small FIFO and emits an 8-bit z stream, with a frame-last flag, suitable as x input for the next conv layer.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
LOGDEPTH, 2, log2(DEPTH)
OUTS_PER_FRAME, 5, outputs per convolution frame (N-M+1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cfg_shift  in  5  right-shift amount; must be stable while any data is in flight
s_data_in_y  in  18  signed conv result
s_valid_y  in  1  upstream data valid
s_ready_y  out  1  block can accept y
m_data_out_z  out  8  signed requantised result
m_valid_z  out  1  z valid
m_ready_z  in  1  downstream accepts z
m_last_z  out  1  high with the last z of each frame

Behaviour:
- Reset (async, active-high): stage1 valid=0, FIFO count=0, rd/wr pointers=0, frame counter=0; s_ready_y=0 while reset is high, m_valid_z=0, m_last_z=0, m_data_out_z=0.
- Occupancy occ = fifo_count + stage1_valid. s_ready_y = !reset && (occ < DEPTH). Accept on s_valid_y && s_ready_y at a rising edge.
- Stage1 (registered): captures the accepted y, last bit (frame counter == OUTS_PER_FRAME-1) and computed value.
- Frame counter increments on accept and wraps to 0 after OUTS_PER_FRAME-1.
- Arithmetic, combinational into stage1, 20-bit signed intermediate:
  - sh = min(cfg_shift, 17).
  - If sh>0, t = (y + (1<<(sh-1))) >>> sh; if sh=0, t = y.
  - Saturate t to [-128,127].
- Stage1 writes to FIFO on the next edge, unconditionally when stage1_valid. Space is guaranteed by the occ rule.
- FIFO: storage is 9 bits per entry (data plus last). m_data_out_z and m_last_z are read combinationally from mem[rd_ptr]. m_valid_z = (count != 0). When m_valid_z=0, m_data_out_z=0 and m_last_z=0.
- Pop on m_valid_z && m_ready_z. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Latency: y accepted at edge k gives m_valid_z high after edge k+1 when the FIFO was empty. Throughput is 1 per cycle when m_ready_z is held high.
- Full: occ == DEPTH drops s_ready_y. It rises the cycle after a pop frees a slot; registered-count based, so there is no combinational ready path from m_ready_z.
- Empty: m_ready_z is ignored and no pop occurs.
- Reset mid-operation: all in-flight and buffered data is discarded and the frame counter restarts. The first post-reset output is frame index 0.
- X on s_data_in_y while s_valid_y=0 must never propagate to outputs.

Optional Feature:
CONV_REQ_RELU_EN
- Defined: after saturation, negative values are forced to 0 (ReLU); output range is [0,127].
- Undefined: signed saturation only; output range is [-128,127].
- No port or timing difference.

Decomposition:
- Package conv_pkg:
  - Y_W=18, Z_W=8, SHIFT_W=5, MAX_SHIFT=17
  - typedef logic signed [Y_W-1:0] y_t
  - typedef logic signed [Z_W-1:0] z_t
  - typedef struct {z_t data; logic last;} z_entry_t
  - function requant(y_t, shift) returning z_t, shared with bench model
- One sub-module: conv_out_fifo, parameterised by DEPTH and the entry type, providing push/pop/count/full/empty. The top level holds stage1, the frame counter and the ready logic.

Test Plan:
- cfg_shift=4, y=100 then y=-100, m_ready_z=1 -> z=6 then z=-6. With CONV_REQ_RELU_EN defined, z=6 then 0. First z is valid 2 cycles after the first accept.
- cfg_shift=0, y=131071, -131072, 127, -128 -> z=127, -128, 127, -128. Under RELU, the negatives give 0.
- cfg_shift=20 (clamped to 17), y=65536 -> 1; y=-65537 -> -1 (round-half-up of -0.5000076 -> floor(-0.0000076) -> -1).
- m_ready_z=0, s_valid_y=1 continuously -> exactly 4 accepts, then s_ready_y=0. Then m_ready_z=1 -> 4 z values in input order, and s_ready_y returns high one cycle after the first pop.
- 10 consecutive y with random m_ready_z -> m_last_z high only on z #5 and #10; no loss or duplication vs the requant model.
- Reset asserted asynchronously with 3 items buffered -> m_valid_z=0 immediately. After release, the next 5 inputs give m_last_z on the 5th.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and requantisation arithmetic for the conv output stage.
// Build option: CONV_REQ_RELU_EN clamps negative results to zero.
package conv_pkg;

  localparam int Y_W       = 18;
  localparam int Z_W       = 8;
  localparam int SHIFT_W   = 5;
  localparam int MAX_SHIFT = 17;
  localparam int I_W       = 20;

  typedef logic signed [Y_W-1:0] y_t;
  typedef logic signed [Z_W-1:0] z_t;

  typedef struct packed {
    z_t   data;
    logic last;
  } z_entry_t;

  function automatic z_t requant(
    input y_t               y,
    input logic [SHIFT_W-1:0] shift
  );
    logic [SHIFT_W-1:0]    sh;
    logic signed [I_W-1:0] ext;
    logic signed [I_W-1:0] rnd;
    logic signed [I_W-1:0] t;
    z_t                    z;
    sh  = (shift > SHIFT_W'(MAX_SHIFT))
        ? SHIFT_W'(MAX_SHIFT) : shift;
    ext = {{(I_W-Y_W){y[Y_W-1]}}, y};
    rnd = (sh == '0) ? '0
        : (I_W'(1) <<< (sh - 1'b1));
    t   = (ext + rnd) >>> sh;
    if (t > 20'sd127)
      z = 8'sd127;
    else if (t < -20'sd128)
      z = -8'sd128;
    else
      z = t[Z_W-1:0];
`ifdef CONV_REQ_RELU_EN
    if (z < 0)
      z = '0;
`else
`endif
    return z;
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Small circular FIFO for requantised z entries.
// Build option: CONV_REQ_RELU_EN (no effect on this block).
module conv_out_fifo
  import conv_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter int  LOGDEPTH = 2,
  parameter type T        = z_entry_t
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  T                  wdata,
  input  logic              pop,
  output T                  rdata,
  output logic [LOGDEPTH:0] count,
  output logic              full,
  output logic              empty
);

  T                    mem [DEPTH];
  logic [LOGDEPTH-1:0] rd_ptr;
  logic [LOGDEPTH-1:0] wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == (LOGDEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/conv_requant_out.sv
// Requantises the conv y stream to saturated 8-bit z with frame-last.
// Build option: CONV_REQ_RELU_EN clamps negative results to zero.
module conv_requant_out
  import conv_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int LOGDEPTH       = 2,
  parameter int OUTS_PER_FRAME = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [Y_W-1:0]     s_data_in_y,
  input  logic               s_valid_y,
  output logic               s_ready_y,
  output logic [Z_W-1:0]     m_data_out_z,
  output logic               m_valid_z,
  input  logic               m_ready_z,
  output logic               m_last_z
);

  localparam int FC_W =
    (OUTS_PER_FRAME > 1) ? $clog2(OUTS_PER_FRAME) : 1;

  logic                s1_valid;
  z_entry_t            s1_entry;
  logic [FC_W-1:0]     fcnt;
  logic                fc_last;
  logic                accept;
  logic [LOGDEPTH+1:0] occ;
  logic [LOGDEPTH:0]   count;
  logic                full;
  logic                empty;
  z_entry_t            rdata;

  assign fc_last   = (fcnt == FC_W'(OUTS_PER_FRAME-1));
  assign occ       = (LOGDEPTH+2)'(count)
                   + (LOGDEPTH+2)'(s1_valid);
  assign s_ready_y = !reset && !full
                   && (occ < (LOGDEPTH+2)'(DEPTH));
  assign accept    = s_valid_y && s_ready_y;

  // Stage1 register: requantised value and frame-last flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_entry.data <= requant(y_t'(s_data_in_y), cfg_shift);
        s1_entry.last <= fc_last;
      end
    end
  end

  // Frame position counter, advances per accepted y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fcnt <= '0;
    else if (accept)
      fcnt <= fc_last ? '0 : fcnt + 1'b1;
  end

  conv_out_fifo #(
    .DEPTH    (DEPTH),
    .LOGDEPTH (LOGDEPTH),
    .T        (z_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid),
    .wdata (s1_entry),
    .pop   (m_ready_z),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign m_valid_z    = !empty;
  assign m_data_out_z = empty ? '0 : rdata.data;
  assign m_last_z     = empty ? 1'b0 : rdata.last;

endmodule
